// File: rtl/adxl_pkg.sv
// Shared opcodes, register map, FSM encoding and command table for the ADXL362 sequencer.
package adxl_pkg;

  localparam logic [7:0] ADXL_WR    = 8'h0A;
  localparam logic [7:0] ADXL_RD    = 8'h0B;

  localparam logic [7:0] FILTER_CTL = 8'h2C;
  localparam logic [7:0] POWER_CTL  = 8'h2D;
  localparam logic [7:0] XDATA      = 8'h08;
  localparam logic [7:0] YDATA      = 8'h09;
  localparam logic [7:0] ZDATA      = 8'h0A;

  localparam logic [2:0] IDX_FILTER = 3'd0;
  localparam logic [2:0] IDX_POWER  = 3'd1;
  localparam logic [2:0] IDX_X      = 3'd2;
  localparam logic [2:0] IDX_Y      = 3'd3;
  localparam logic [2:0] IDX_Z      = 3'd4;

  typedef enum logic [2:0] {
    ST_BOOT_WAIT   = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_READY  = 3'd2,
    ST_GAP         = 3'd3,
    ST_SAMPLE_WAIT = 3'd4,
    ST_IDLE        = 3'd5,
    ST_RECOVER     = 3'd6
  } adxl_state_e;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
  } adxl_cmd_t;

  // Command table: two config writes followed by the three axis reads.
  function automatic adxl_cmd_t cmd_lookup(input logic [2:0] idx,
                                           input logic [7:0] filter_cfg,
                                           input logic [7:0] power_cfg);
    adxl_cmd_t c;
    c = '{opcode: ADXL_RD, addr: XDATA, data: 8'h00};
    case (idx)
      IDX_FILTER: c = '{opcode: ADXL_WR, addr: FILTER_CTL, data: filter_cfg};
      IDX_POWER:  c = '{opcode: ADXL_WR, addr: POWER_CTL,  data: power_cfg};
      IDX_X:      c = '{opcode: ADXL_RD, addr: XDATA,      data: 8'h00};
      IDX_Y:      c = '{opcode: ADXL_RD, addr: YDATA,      data: 8'h00};
      IDX_Z:      c = '{opcode: ADXL_RD, addr: ZDATA,      data: 8'h00};
      default:    c = '{opcode: ADXL_RD, addr: XDATA,      data: 8'h00};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adxl_command_sequencer_if.sv
// Command port between the sequencer (master) and SPI_controller (slave).
interface adxl_command_sequencer_if;
  logic        start_command;
  logic [23:0] COMMAND;
  logic        ADXL_OUT_ready;
  logic [23:0] c_ADXL_OUT;

  modport master (output start_command, COMMAND, input ADXL_OUT_ready, c_ADXL_OUT);
  modport slave  (input start_command, COMMAND, output ADXL_OUT_ready, c_ADXL_OUT);
endinterface

// File: rtl/cycle_timer.sv
// Saturating up-counter; load sets the count to 1 so done marks the limit-th cycle since load.
module cycle_timer #(
  parameter  int unsigned MAX_CYCLES = 16,
  localparam int unsigned W          = $clog2(MAX_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] limit,
  output logic         done_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = W'(1);
    end else if (cnt_q < limit) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q >= limit);

endmodule

// File: rtl/adxl_command_sequencer.sv
// Boots, configures and periodically samples an ADXL362 through SPI_controller's command port.
module adxl_command_sequencer
  import adxl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES    = 500000,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned SAMPLE_CYCLES  = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  FILTER_CFG     = 8'h13,
  parameter logic [7:0]  POWER_CFG      = 8'h02
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  adxl_command_sequencer_if.master   spi,
  output logic [7:0]                 x_data,
  output logic [7:0]                 y_data,
  output logic [7:0]                 z_data,
  output logic                       sample_valid,
  output logic                       init_done,
  output logic                       timeout_err
);

  localparam int unsigned GEN_MAX = (BOOT_CYCLES > GAP_CYCLES) ? BOOT_CYCLES : GAP_CYCLES;
  localparam int unsigned GEN_W   = $clog2(GEN_MAX + 1);
  localparam int unsigned FRAME_W = $clog2(SAMPLE_CYCLES + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  adxl_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] command_q, command_d;
  logic        start_command_q, start_command_d;
  logic [7:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic        sample_valid_q, sample_valid_d;
  logic        init_done_q, init_done_d;
  logic        timeout_err_q, timeout_err_d;

  logic        gen_done, frame_done, to_done;
  logic        issue_entry, gen_load, frame_load, to_load;
  logic [GEN_W-1:0] gen_limit;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^spi.c_ADXL_OUT[23:8];

  // Boot delay and inter-command gap share one timer.
  assign gen_limit = (state_q == ST_BOOT_WAIT) ? GEN_W'(BOOT_CYCLES) : GEN_W'(GAP_CYCLES);

  cycle_timer #(.MAX_CYCLES(GEN_MAX)) u_gen_timer (
    .clk(clk), .reset(reset), .load(gen_load), .limit(gen_limit), .done_c(gen_done)
  );

  cycle_timer #(.MAX_CYCLES(SAMPLE_CYCLES)) u_frame_timer (
    .clk(clk), .reset(reset), .load(frame_load), .limit(FRAME_W'(SAMPLE_CYCLES)),
    .done_c(frame_done)
  );

  // Timeout timer also paces the RECOVER drain window.
  cycle_timer #(.MAX_CYCLES(TIMEOUT_CYCLES)) u_to_timer (
    .clk(clk), .reset(reset), .load(to_load), .limit(TO_W'(TIMEOUT_CYCLES)), .done_c(to_done)
  );

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    command_d       = command_q;
    start_command_d = 1'b0;
    x_d             = x_q;
    y_d             = y_q;
    z_d             = z_q;
    sample_valid_d  = 1'b0;
    init_done_d     = init_done_q;
    timeout_err_d   = timeout_err_q;

    case (state_q)
      ST_BOOT_WAIT: begin
        if (gen_done && enable) begin
          state_d = ST_ISSUE;
          idx_d   = IDX_FILTER;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_READY;
      ST_WAIT_READY: begin
        // Ready takes priority over a coincident timeout.
        if (spi.ADXL_OUT_ready) begin
          case (idx_q)
            IDX_POWER: init_done_d = 1'b1;
            IDX_X:     x_d = spi.c_ADXL_OUT[7:0];
            IDX_Y:     y_d = spi.c_ADXL_OUT[7:0];
            IDX_Z: begin
              z_d            = spi.c_ADXL_OUT[7:0];
              sample_valid_d = 1'b1;
            end
            default: ;
          endcase
          state_d = ST_GAP;
        end else if (to_done) begin
          state_d       = ST_RECOVER;
          timeout_err_d = 1'b1;
          init_done_d   = 1'b0;
        end
      end
      ST_GAP: begin
        if (gen_done) begin
          if (idx_q != IDX_Z) begin
            state_d = ST_ISSUE;
            idx_d   = idx_q + 3'd1;
          end else if (!frame_done) begin
            state_d = ST_SAMPLE_WAIT;
          end else if (enable) begin
            state_d = ST_ISSUE;
            idx_d   = IDX_X;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SAMPLE_WAIT: begin
        if (frame_done) begin
          if (enable) begin
            state_d = ST_ISSUE;
            idx_d   = IDX_X;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_ISSUE;
          idx_d   = init_done_q ? IDX_X : IDX_FILTER;
        end
      end
      ST_RECOVER: begin
        if (to_done) begin
          state_d = ST_ISSUE;
          idx_d   = IDX_FILTER;
        end
      end
      default: state_d = ST_BOOT_WAIT;
    endcase

    issue_entry = (state_d == ST_ISSUE) && (state_q != ST_ISSUE);
    if (issue_entry) begin
      start_command_d = 1'b1;
      command_d       = cmd_lookup(idx_d, FILTER_CFG, POWER_CFG);
    end

    gen_load   = (state_d == ST_GAP) && (state_q != ST_GAP);
    frame_load = issue_entry && (idx_d == IDX_X);
    to_load    = issue_entry || ((state_d == ST_RECOVER) && (state_q != ST_RECOVER));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_BOOT_WAIT;
      idx_q           <= IDX_FILTER;
      command_q       <= '0;
      start_command_q <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      z_q             <= '0;
      sample_valid_q  <= 1'b0;
      init_done_q     <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      command_q       <= command_d;
      start_command_q <= start_command_d;
      x_q             <= x_d;
      y_q             <= y_d;
      z_q             <= z_d;
      sample_valid_q  <= sample_valid_d;
      init_done_q     <= init_done_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign spi.start_command = start_command_q;
  assign spi.COMMAND       = command_q;
  assign x_data            = x_q;
  assign y_data            = y_q;
  assign z_data            = z_q;
  assign sample_valid      = sample_valid_q;
  assign init_done         = init_done_q;
  assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_adxl_command_sequencer.sv
// Directed bench for adxl_command_sequencer with a small SPI_controller responder model.
module tb_adxl_command_sequencer;

  localparam int unsigned BOOT = 10;
  localparam int unsigned GAP  = 4;
  localparam int unsigned SAMP = 200;
  localparam int unsigned TMO  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] x_data, y_data, z_data;
  logic       sample_valid, init_done, timeout_err;

  adxl_command_sequencer_if ifc();

  adxl_command_sequencer #(
    .BOOT_CYCLES(BOOT), .GAP_CYCLES(GAP), .SAMPLE_CYCLES(SAMP), .TIMEOUT_CYCLES(TMO),
    .FILTER_CFG(8'h13), .POWER_CFG(8'h02)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .spi(ifc),
    .x_data(x_data), .y_data(y_data), .z_data(z_data),
    .sample_valid(sample_valid), .init_done(init_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] cmd;
    int          delta;
    logic [7:0]  rdata;
    logic        init_exp;
    logic [7:0]  x_exp;
    logic [7:0]  y_exp;
    logic [7:0]  z_exp;
    logic        sv_exp;
  } vec_t;

  vec_t vecs[8];

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         mark = 0;
  int         at = 0;
  int         nstarts = 0;
  logic       start_now = 1'b0;

  // Responder state
  int         resp_delay = 30;
  logic [7:0] resp_data = 8'h00;
  bit         withhold_en = 1'b0;
  logic [7:0] withhold_addr = 8'h00;
  bit         pend = 1'b0;
  int         pend_cnt = 0;
  bit         stray = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe DUT after the edge, then drive the responder for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    start_now = ifc.start_command;
    ifc.ADXL_OUT_ready = 1'b0;
    ifc.c_ADXL_OUT     = 24'h0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        pend               = 1'b0;
        ifc.ADXL_OUT_ready = 1'b1;
        ifc.c_ADXL_OUT     = {16'h0, resp_data};
      end
    end
    if (stray) begin
      stray              = 1'b0;
      ifc.ADXL_OUT_ready = 1'b1;
      ifc.c_ADXL_OUT     = {16'h0, resp_data};
    end
    if (start_now && !(withhold_en && ifc.COMMAND[15:8] == withhold_addr)) begin
      pend     = 1'b1;
      pend_cnt = resp_delay;
    end
  endtask

  task automatic wait_start(input int budget, input string name, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (start_now) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no start_command within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.ADXL_OUT_ready = 1'b0;
    ifc.c_ADXL_OUT     = 24'h0;

    vecs[0] = '{24'h0A2C13,  11, 8'hEE, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{24'h0A2D02,  35, 8'hEE, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{24'h0B0800,  35, 8'h12, 1'b1, 8'h12, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{24'h0B0900,  35, 8'h34, 1'b1, 8'h12, 8'h34, 8'h00, 1'b0};
    vecs[4] = '{24'h0B0A00,  35, 8'h56, 1'b1, 8'h12, 8'h34, 8'h56, 1'b1};
    vecs[5] = '{24'h0B0800, 130, 8'h9A, 1'b1, 8'h9A, 8'h34, 8'h56, 1'b0};
    vecs[6] = '{24'h0B0900,  35, 8'hBC, 1'b1, 8'h9A, 8'hBC, 8'h56, 1'b0};
    vecs[7] = '{24'h0B0A00,  35, 8'hDE, 1'b1, 8'h9A, 8'hBC, 8'hDE, 1'b1};

    // Reset state
    repeat (3) tick();
    check("rst_start", 32'(ifc.start_command), 32'(0));
    check("rst_cmd",   32'(ifc.COMMAND), 32'(0));
    check("rst_x",     32'(x_data), 32'(0));
    check("rst_y",     32'(y_data), 32'(0));
    check("rst_z",     32'(z_data), 32'(0));
    check("rst_sv",    32'(sample_valid), 32'(0));
    check("rst_init",  32'(init_done), 32'(0));
    check("rst_err",   32'(timeout_err), 32'(0));

    // Boot, configuration and two full frames
    reset = 1'b0;
    mark  = cyc;
    for (int i = 0; i < 8; i++) begin
      wait_start(400, $sformatf("v%0d_wait", i), at);
      check($sformatf("v%0d_delta", i), 32'(at - mark), 32'(vecs[i].delta));
      check($sformatf("v%0d_cmd", i), 32'(ifc.COMMAND), 32'(vecs[i].cmd));
      mark      = at;
      resp_data = vecs[i].rdata;
      repeat (31) tick();
      check($sformatf("v%0d_init", i), 32'(init_done), 32'(vecs[i].init_exp));
      check($sformatf("v%0d_x", i), 32'(x_data), 32'(vecs[i].x_exp));
      check($sformatf("v%0d_y", i), 32'(y_data), 32'(vecs[i].y_exp));
      check($sformatf("v%0d_z", i), 32'(z_data), 32'(vecs[i].z_exp));
      check($sformatf("v%0d_sv", i), 32'(sample_valid), 32'(vecs[i].sv_exp));
      tick();
      check($sformatf("v%0d_sv_end", i), 32'(sample_valid), 32'(0));
    end

    // enable dropped during the Y read: frame completes, then park in IDLE
    wait_start(400, "en_x_wait", at);
    check("en_x_delta", 32'(at - mark), 32'(130));
    resp_data = 8'h11;
    mark = at;
    wait_start(100, "en_y_wait", at);
    check("en_y_cmd", 32'(ifc.COMMAND), 32'(24'h0B0900));
    resp_data = 8'h22;
    enable    = 1'b0;
    mark = at;
    wait_start(100, "en_z_wait", at);
    check("en_z_delta", 32'(at - mark), 32'(35));
    check("en_z_cmd", 32'(ifc.COMMAND), 32'(24'h0B0A00));
    resp_data = 8'h33;
    repeat (31) tick();
    check("en_sv", 32'(sample_valid), 32'(1));
    check("en_z", 32'(z_data), 32'(8'h33));
    nstarts = 0;
    repeat (500) begin
      tick();
      if (start_now) nstarts++;
    end
    check("en_quiet", 32'(nstarts), 32'(0));
    enable = 1'b1;
    mark   = cyc;
    wait_start(5, "en_resume_wait", at);
    check("en_resume_delta", 32'(at - mark), 32'(1));
    check("en_resume_cmd", 32'(ifc.COMMAND), 32'(24'h0B0800));

    // Y read never answered: timeout, recover, full re-init
    resp_data     = 8'h44;
    withhold_en   = 1'b1;
    withhold_addr = 8'h09;
    wait_start(100, "to_y_wait", at);
    check("to_y_cmd", 32'(ifc.COMMAND), 32'(24'h0B0900));
    repeat (63) tick();
    check("to_err_before", 32'(timeout_err), 32'(0));
    tick();
    check("to_err_set", 32'(timeout_err), 32'(1));
    check("to_init_clr", 32'(init_done), 32'(0));
    withhold_en = 1'b0;
    mark = cyc;
    wait_start(200, "to_reinit_wait", at);
    check("to_reinit_delta", 32'(at - mark), 32'(64));
    check("to_reinit_cmd", 32'(ifc.COMMAND), 32'(24'h0A2C13));
    check("to_err_sticky", 32'(timeout_err), 32'(1));

    // Reset in the middle of WAIT_READY
    repeat (10) tick();
    reset = 1'b1;
    pend  = 1'b0;
    tick();
    check("mr_start", 32'(ifc.start_command), 32'(0));
    check("mr_cmd",   32'(ifc.COMMAND), 32'(0));
    check("mr_x",     32'(x_data), 32'(0));
    check("mr_err",   32'(timeout_err), 32'(0));
    check("mr_init",  32'(init_done), 32'(0));
    nstarts = 0;
    repeat (3) begin
      tick();
      if (start_now) nstarts++;
    end
    check("mr_no_start", 32'(nstarts), 32'(0));
    reset = 1'b0;
    mark  = cyc;
    wait_start(50, "mr_boot_wait", at);
    check("mr_boot_delta", 32'(at - mark), 32'(11));
    check("mr_boot_cmd", 32'(ifc.COMMAND), 32'(24'h0A2C13));

    // Stray ready in GAP; ready on the timeout cycle
    resp_data = 8'hEE;
    wait_start(100, "sr_pwr_wait", at);
    wait_start(100, "sr_x_wait", at);
    check("sr_x_cmd", 32'(ifc.COMMAND), 32'(24'h0B0800));
    resp_data = 8'h5A;
    repeat (31) tick();
    check("sr_x", 32'(x_data), 32'(8'h5A));
    resp_data = 8'hA5;
    stray     = 1'b1;
    tick();
    tick();
    check("sr_stray_x", 32'(x_data), 32'(8'h5A));
    resp_delay = 63;
    mark = cyc - 33;
    wait_start(100, "sr_y_wait", at);
    check("sr_y_delta", 32'(at - mark), 32'(35));
    resp_delay = 30;
    resp_data  = 8'h77;
    mark = at;
    wait_start(200, "edge_z_wait", at);
    check("edge_z_delta", 32'(at - mark), 32'(68));
    check("edge_y", 32'(y_data), 32'(8'h77));
    check("edge_err", 32'(timeout_err), 32'(0));
    check("edge_init", 32'(init_done), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
